accum_mod2nm1: RTL and testbench
================================

Name: accum_mod2nm1

Overview:
- Framed streaming accumulator modulo (2^width - 1) for residue-number and checksum datapaths.
- Sums a variable-length frame of operands, one operand per cycle, using the end-around-carry modulo adder (AddMod2Nm1, same width/speed).
- Returns the frame sum, the operand count and a count-saturation flag over a valid/ready handshake.
- Adds an optional single-zero output normalisation that the plain adder does not have.

Parameters:
- width, 8, operand/sum word width; must be >= 2
- speed, lau_pkg::FAST, passed unchanged to the internal modulo adder
- cntWidth, 8, operand counter width; saturates at 2^cntWidth - 1
- normZero, 0, 1 = output all-ones is mapped to all-zeros (single-zero representation); 0 = double-zero representation passed through

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- InValid  in  1  operand valid
- InReady  out  1  block accepts an operand this cycle
- InData  in  width  operand
- InLast  in  1  operand is the last of its frame
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts the result
- OutSum  out  width  frame sum mod (2^width - 1)
- OutCount  out  cntWidth  operands in the frame, saturating
- OutSat  out  1  count saturated during the frame

Behaviour:
- Reset and interface timing:
  - One clock, CLK. RST is synchronous and active-high.
  - All state and outputs are registered.
  - While RST is high and on the cycle after it: state = IDLE; acc, cnt, OutSum, OutCount = 0; OutSat = 0; OutValid = 0; InReady = 0 during RST, then 1.
- Transfers: an input transfer occurs when InValid & InReady; an output transfer occurs when OutValid & OutReady.
- FSM, three states:
  - IDLE: no partial sum. InReady = 1. On transfer: acc <= InData, cnt <= 1, sat <= 0. Next state = HOLD if InLast, else ACC.
  - ACC: InReady = 1. On transfer: acc <= AddMod2Nm1(acc, InData).
    - cnt increments; if cnt == 2^cntWidth - 1 it holds and sat <= 1.
    - Next state = HOLD if InLast, else ACC.
    - No transfer: acc and cnt hold. There is no timeout.
  - HOLD: InReady = 0 and OutValid = 1. OutSum, OutCount and OutSat are stable until the output transfer. On transfer: next state = IDLE, OutValid <= 0.
- Latency and throughput:
  - The result is visible (OutValid = 1) the cycle after the InLast transfer.
  - A frame of k operands occupies at least k + 1 cycles. There is no accept/emit overlap.
- Arithmetic: one's-complement addition with end-around carry. A double-zero representation is kept internally: all-ones is a valid zero and is never forced inside acc.
- Output mapping: OutSum = (normZero && acc == all-ones) ? 0 : acc. The mapping is applied when entering HOLD, not per-cycle combinationally on acc.
- Simultaneous events: in HOLD, InValid is ignored and the operand must stay stable upstream. OutReady outside HOLD is ignored.
- Reset mid-frame or mid-HOLD: the partial sum and pending result are discarded without emission.
- InLast is sampled only on an input transfer.

Test Plan:
- width=8, normZero=0: frame {200,100 last} -> OutSum=45, OutCount=2, OutSat=0, OutValid one cycle after the last transfer.
- Zero representations: frame {128,127 last} -> 255 with normZero=0; same frame with normZero=1 -> 0. Frame {255,255 last} -> 255 with normZero=0.
- Single-operand frame {37 last} issued from IDLE -> OutSum=37, OutCount=1; state returns to IDLE on the output transfer and InReady=1 the next cycle.
- Backpressure: hold OutReady=0 for 3 cycles while InValid=1 with the next frame's 5 -> InReady=0 throughout; outputs stable; the next frame starts the cycle after OutReady rises.
- cntWidth=2: frame of 5 operands {1,1,1,1,1 last} -> OutSum=5, OutCount=3, OutSat=1.
- Assert RST for one cycle after 2 operands of a frame -> no OutValid. The following frame {10,20 last} -> OutSum=30, OutCount=2.

Source files
------------

// File: rtl/accum_mod2nm1.sv
// Framed streaming accumulator modulo (2^width - 1) with end-around carry.
// Sums one operand per cycle and returns sum, count and saturation flag per frame.

package lau_pkg;
    typedef enum logic {FAST, SLOW} speed_e;
endpackage

module accum_mod2nm1 #(
    parameter int              width    = 8,
    parameter lau_pkg::speed_e speed    = lau_pkg::FAST,
    parameter int              cntWidth = 8,
    parameter bit              normZero = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                InValid,
    output logic                InReady,
    input  logic [width-1:0]    InData,
    input  logic                InLast,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [width-1:0]    OutSum,
    output logic [cntWidth-1:0] OutCount,
    output logic                OutSat
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

    localparam logic [cntWidth-1:0] CNT_ONE = cntWidth'(1);

    state_e              state, next_state;
    logic [width-1:0]    acc, acc_next;
    logic [cntWidth-1:0] cnt, cnt_next;
    logic                sat, sat_next;
    logic                in_xfer, out_xfer;

    // One's-complement add; FAST selects between a+b and a+b+1 on the carry,
    // SLOW feeds the carry back through a second increment.
    function automatic logic [width-1:0] add_mod(input logic [width-1:0] a,
                                                 input logic [width-1:0] b);
        logic [width:0] s0;
        logic [width:0] s1;
        s0 = {1'b0, a} + {1'b0, b};
        s1 = {1'b0, a} + {1'b0, b} + (width+1)'(1);
        if (speed == lau_pkg::FAST)
            return s0[width] ? s1[width-1:0] : s0[width-1:0];
        else
            return s0[width-1:0] + {{(width-1){1'b0}}, s0[width]};
    endfunction

    function automatic logic [cntWidth-1:0] sat_inc(input logic [cntWidth-1:0] c);
        return (c == '1) ? c : c + CNT_ONE;
    endfunction

    function automatic logic [width-1:0] norm_zero(input logic [width-1:0] a);
        return (normZero && (a == '1)) ? '0 : a;
    endfunction

    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;

    always_comb begin
        next_state = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    acc_next   = InData;
                    cnt_next   = CNT_ONE;
                    sat_next   = 1'b0;
                    next_state = InLast ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_xfer) begin
                    acc_next   = add_mod(acc, InData);
                    cnt_next   = sat_inc(cnt);
                    sat_next   = sat | (cnt == '1);
                    next_state = InLast ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_xfer)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result registers load only on entry to HOLD so they stay stable under backpressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
            OutSum   <= '0;
            OutCount <= '0;
            OutSat   <= 1'b0;
            OutValid <= 1'b0;
            InReady  <= 1'b0;
        end else begin
            state    <= next_state;
            acc      <= acc_next;
            cnt      <= cnt_next;
            sat      <= sat_next;
            InReady  <= (next_state != HOLD);
            OutValid <= (next_state == HOLD);
            if ((state != HOLD) && (next_state == HOLD)) begin
                OutSum   <= norm_zero(acc_next);
                OutCount <= cnt_next;
                OutSat   <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_accum_mod2nm1.sv
// Directed bench for accum_mod2nm1: three instances (plain, SLOW + single-zero, 2-bit counter)
// share one stimulus stream; expected frame results are queued and compared on output transfers.

module tb_accum_mod2nm1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_last, out_ready;
    logic [7:0] in_data;

    logic       rdy0, vld0, sat0;
    logic [7:0] sum0, cnt0;
    logic       rdy1, vld1, sat1;
    logic [7:0] sum1, cnt1;
    logic       rdy2, vld2, sat2;
    logic [7:0] sum2;
    logic [1:0] cnt2;

    accum_mod2nm1 #(.width(8), .speed(lau_pkg::FAST), .cntWidth(8), .normZero(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .InValid(in_valid), .InReady(rdy0), .InData(in_data),
        .InLast(in_last), .OutValid(vld0), .OutReady(out_ready), .OutSum(sum0),
        .OutCount(cnt0), .OutSat(sat0));

    accum_mod2nm1 #(.width(8), .speed(lau_pkg::SLOW), .cntWidth(8), .normZero(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .InValid(in_valid), .InReady(rdy1), .InData(in_data),
        .InLast(in_last), .OutValid(vld1), .OutReady(out_ready), .OutSum(sum1),
        .OutCount(cnt1), .OutSat(sat1));

    accum_mod2nm1 #(.width(8), .speed(lau_pkg::FAST), .cntWidth(2), .normZero(1'b0)) dut2 (
        .CLK(clk), .RST(rst), .InValid(in_valid), .InReady(rdy2), .InData(in_data),
        .InLast(in_last), .OutValid(vld2), .OutReady(out_ready), .OutSum(sum2),
        .OutCount(cnt2), .OutSat(sat2));

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] c0;
        logic [1:0] c2;
        logic       sat0;
        logic       sat2;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   frame_total = 0;
    int   frame_k = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: any nonzero total that is a multiple of 255 reads back as all-ones.
    function automatic logic [7:0] mod_ref(input int total);
        if (total == 0)
            return 8'd0;
        else if ((total % 255) == 0)
            return 8'd255;
        else
            return 8'(total % 255);
    endfunction

    task automatic account(input logic [7:0] d, input logic last);
        exp_t e;
        frame_total += int'(d);
        frame_k++;
        if (last) begin
            e.s0   = mod_ref(frame_total);
            e.s1   = (e.s0 == 8'd255) ? 8'd0 : e.s0;
            e.c0   = (frame_k > 255) ? 8'd255 : 8'(frame_k);
            e.c2   = (frame_k > 3) ? 2'd3 : 2'(frame_k);
            e.sat0 = (frame_k > 255);
            e.sat2 = (frame_k > 3);
            sb.push_back(e);
            frame_total = 0;
            frame_k     = 0;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            ok = rdy0;
            @(posedge clk);
            #1;
        end
        chk("operand_accepted", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok)
            account(d, last);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("results_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && vld0 && out_ready) begin
            chk("result_was_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sum_dut0", sum0, e.s0);
                chk("count_dut0", cnt0, e.c0);
                chk("sat_dut0", sat0, e.sat0);
                chk("valid_dut1", vld1, 1);
                chk("sum_dut1_norm", sum1, e.s1);
                chk("count_dut1", cnt1, e.c0);
                chk("sat_dut1", sat1, e.sat0);
                chk("valid_dut2", vld2, 1);
                chk("sum_dut2", sum2, e.s0);
                chk("count_dut2", cnt2, e.c2);
                chk("sat_dut2", sat2, e.sat2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ready", rdy0, 0);
        chk("reset_ready_dut1", rdy1, 0);
        chk("reset_valid", vld0, 0);
        chk("reset_sum", sum0, 0);
        chk("reset_count", cnt0, 0);
        chk("reset_sat", sat0, 0);
        chk("reset_count_dut2", cnt2, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ready_after_reset", rdy0, 1);
        chk("valid_after_reset", vld0, 0);
        @(posedge clk);
        #1;

        // {200,100}: end-around carry, result one cycle after the last transfer
        send(8'd200, 1'b0);
        send(8'd100, 1'b1);
        @(negedge clk);
        chk("latency_valid", vld0, 1);
        chk("hold_not_ready", rdy0, 0);
        @(posedge clk);
        #1;
        drain();

        // zero representations
        send(8'd128, 1'b0);
        send(8'd127, 1'b1);
        drain();
        send(8'd255, 1'b0);
        send(8'd255, 1'b1);
        drain();

        // single-operand frame, back to IDLE after the output transfer
        send(8'd37, 1'b1);
        @(negedge clk);
        chk("single_valid", vld0, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_ready", rdy0, 1);
        chk("idle_no_valid", vld0, 0);
        @(posedge clk);
        #1;
        drain();

        // backpressure with the next operand already offered
        out_ready = 1'b0;
        send(8'd50, 1'b0);
        send(8'd60, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'd5;
        in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", rdy0, 0);
            chk("bp_ready_dut2", rdy2, 0);
            chk("bp_valid", vld0, 1);
            chk("bp_sum", sum0, 110);
            chk("bp_count", cnt0, 2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_hold", rdy0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("next_frame_ready", rdy0, 1);
        @(posedge clk);
        #1;
        account(8'd5, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("next_frame_valid", vld0, 1);
        @(posedge clk);
        #1;
        drain();

        // counter saturation in the 2-bit instance
        repeat (4) send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        drain();

        // reset mid-frame discards the partial sum
        send(8'd7, 1'b0);
        send(8'd8, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        frame_total = 0;
        frame_k     = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_valid_after_reset", vld0, 0);
            @(posedge clk);
            #1;
        end
        send(8'd10, 1'b0);
        send(8'd20, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
